// File: rtl/binary_to_bcd_converter_pkg.sv
// Shared definitions for the binary-to-BCD converter: state encoding,
// default sizes and the decimal limit constants.
package binary_to_bcd_converter_pkg;

    localparam int BIN_WIDTH_DEF = 27;
    localparam int DIGITS_DEF    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic longint unsigned bcd_max_of(input int digits);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < digits; i++) begin
            acc = acc * 64'd10;
        end
        return acc - 64'd1;
    endfunction

    localparam longint unsigned        BCD_MAX = bcd_max_of(DIGITS_DEF);
    localparam logic [4*DIGITS_DEF-1:0] BCD_SAT = {DIGITS_DEF{4'h9}};

endpackage

// File: rtl/binary_to_bcd_converter_bcd_digit_adjust.sv
// Double-dabble digit correction: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust (
    input  logic [3:0] digit_in,
    input  logic [3:0] digit_out_unused_n,
    output logic [3:0] digit_out
);

    // Add-3 correction, no carry out of the nibble.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end else begin
            digit_out = digit_in;
        end
    end

endmodule

// File: rtl/binary_to_bcd_converter.sv
// Sequential double-dabble converter: one shift per clock, start/busy/done
// handshake, saturating to all nines when the input exceeds DIGITS digits.
module binary_to_bcd_converter
    import binary_to_bcd_converter_pkg::*;
#(
    parameter int BIN_WIDTH = BIN_WIDTH_DEF,
    parameter int DIGITS    = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_WIDTH-1:0]  binaryIn,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcdOut,
    output logic                  overflow
);

    localparam int              CNT_W    = $clog2(BIN_WIDTH + 1);
    localparam int              CAT_W    = 4*DIGITS + BIN_WIDTH;
    localparam longint unsigned MAX_VAL  = bcd_max_of(DIGITS);
    // When the binary range never reaches 10^DIGITS the comparison is moot.
    localparam bit              OVF_POSSIBLE = (MAX_VAL < ((64'd1 << BIN_WIDTH) - 64'd1));
    localparam logic [BIN_WIDTH-1:0] MAX_BIN = BIN_WIDTH'(MAX_VAL);
    localparam logic [4*DIGITS-1:0]  SAT_VAL = {DIGITS{4'h9}};

    conv_state_t            state_r;
    conv_state_t            next_state_s;
    logic [BIN_WIDTH-1:0]   shift_r;
    logic [4*DIGITS-1:0]    scratch_r;
    logic [CNT_W-1:0]       count_r;
    logic                   ovf_pending_r;
    logic                   busy_r;
    logic                   done_r;
    logic [4*DIGITS-1:0]    bcd_r;
    logic                   overflow_r;

    logic [4*DIGITS-1:0]    adjusted_s;
    logic [CAT_W-1:0]       shifted_s;
    logic                   ovf_s;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_in           (scratch_r[4*g +: 4]),
            .digit_out_unused_n (4'd0),
            .digit_out          (adjusted_s[4*g +: 4])
        );
    end

    // Adjusted scratch and shift register move left together by one bit.
    always_comb begin
        shifted_s = {adjusted_s, shift_r} << 1;
        ovf_s     = OVF_POSSIBLE && (binaryIn > MAX_BIN);
    end

    // Next-state selection.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (count_r == CNT_W'(1)) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            shift_r       <= '0;
            scratch_r     <= '0;
            count_r       <= '0;
            ovf_pending_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            bcd_r         <= '0;
            overflow_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        shift_r       <= binaryIn;
                        scratch_r     <= '0;
                        count_r       <= CNT_W'(BIN_WIDTH);
                        ovf_pending_r <= ovf_s;
                    end
                end
                SHIFT: begin
                    scratch_r <= shifted_s[CAT_W-1 -: 4*DIGITS];
                    shift_r   <= shifted_s[BIN_WIDTH-1:0];
                    count_r   <= count_r - CNT_W'(1);
                end
                DONE: begin
                    bcd_r      <= ovf_pending_r ? SAT_VAL : scratch_r;
                    overflow_r <= ovf_pending_r;
                    done_r     <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign bcdOut   = bcd_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_binary_to_bcd_converter.sv
// Directed and randomized checks of the binary-to-BCD converter against an
// arithmetic decimal-digit reference.
module tb_binary_to_bcd_converter;

    logic        clk;
    logic        reset;
    logic        start;
    logic [26:0] binaryIn;
    logic        busy;
    logic        done;
    logic [31:0] bcdOut;
    logic        overflow;

    int checks;
    int errors;
    int edge_cnt;
    logic [26:0] hist [0:4095];

    binary_to_bcd_converter dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .binaryIn (binaryIn),
        .busy     (busy),
        .done     (done),
        .bcdOut   (bcdOut),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_bcd(input logic [26:0] v);
        int unsigned n;
        logic [31:0] r;
        n = v;
        r = 32'h0;
        if (n > 32'd99999999) begin
            return 32'h99999999;
        end
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        hist[edge_cnt % 4096] = binaryIn;
        @(posedge clk);
        edge_cnt++;
        #1;
    endtask

    task automatic run_conv(input logic [26:0] v, input string tag);
        int lat;
        binaryIn = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        binaryIn = 27'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!done && lat < 100);
        chk({tag, "_latency"}, 32'(lat), 32'd28);
        chk({tag, "_bcd"}, bcdOut, ref_bcd(v));
        chk({tag, "_ovf"}, 32'(overflow), 32'(v > 27'd99999999));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n_done;
        int last_done;
        logic [31:0] got;
        logic [26:0] v;

        checks = 0;
        errors = 0;
        edge_cnt = 0;
        reset = 1'b1;
        start = 1'b0;
        binaryIn = 27'd0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", bcdOut, 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        tick();

        run_conv(27'd12345678, "c12345678");
        chk("c12345678_exact", bcdOut, 32'h12345678);
        run_conv(27'd0, "czero");
        chk("czero_exact", bcdOut, 32'h00000000);
        run_conv(27'd99999999, "cmax");
        chk("cmax_exact", bcdOut, 32'h99999999);
        run_conv(27'd134217727, "call1");
        chk("call1_ovf_exact", 32'(overflow), 32'd1);
        run_conv(27'd42, "c42");
        chk("c42_exact", bcdOut, 32'h00000042);
        chk("c42_ovf_clear", 32'(overflow), 32'd0);

        // Extra starts while busy, including the final busy cycle, are dropped.
        binaryIn = 27'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        got = 32'h0;
        for (int i = 1; i <= 70; i++) begin
            start = (i == 3 || i == 10 || i == 28);
            binaryIn = start ? 27'd77 : 27'd5;
            tick();
            if (done) begin
                n_done++;
                got = bcdOut;
            end
        end
        start = 1'b0;
        chk("ign_done_count", 32'(n_done), 32'd1);
        chk("ign_bcd", got, 32'h00000005);

        // Reset in the middle of a conversion abandons it.
        binaryIn = 27'd87654321;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd", bcdOut, 32'h0);
        chk("abort_done", 32'(done), 32'd0);
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) n_done++;
        end
        chk("abort_no_done", 32'(n_done), 32'd0);
        run_conv(27'd11, "c11");
        chk("c11_exact", bcdOut, 32'h00000011);

        // Randomized values, with a share clustered around the overflow limit.
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) v = 27'($urandom_range(100000010, 99999990));
            else            v = 27'($urandom_range(134217727, 0));
            run_conv(v, "rand");
        end

        // Continuous start: each result reflects binaryIn on its accept edge.
        start = 1'b1;
        n_done = 0;
        last_done = -1;
        for (int i = 0; i < 130; i++) begin
            binaryIn = 27'(1000 + 37 * i);
            tick();
            if (done) begin
                chk("ramp_bcd", bcdOut, ref_bcd(hist[(edge_cnt - 1 - 28) % 4096]));
                if (last_done >= 0) chk("ramp_period", 32'(edge_cnt - last_done), 32'd29);
                last_done = edge_cnt;
                n_done++;
            end
        end
        start = 1'b0;
        chk("ramp_done_count", 32'(n_done), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd_converter.md
Name: binary_to_bcd_converter

Overview:
- Sequential double-dabble converter that turns an unsigned binary value into packed BCD digits.
- Sits directly upstream of the multiplexed seven-segment display driver. Each 4-bit digit of bcdOut feeds one display position's ssdNumber (digit 0 goes to the rightmost anode).
- Takes one shift per clock, so it fits comfortably in timing at the board clock.
- Uses a start/busy/done handshake so counters and sensors can request a conversion on demand.

Parameters:
- BIN_WIDTH, 27, width of the binary input. 2^27-1 = 134217727 covers 8 decimal digits.
- DIGITS, 8, number of BCD digits produced; matches the 8 display positions.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  conversion request; sampled only when busy=0
- binaryIn  input  BIN_WIDTH  unsigned value; latched on the accepted start cycle
- busy  output  1  high from the cycle after an accepted start through the done cycle
- done  output  1  one-cycle pulse when bcdOut/overflow are updated
- bcdOut  output  4*DIGITS  packed BCD; digit k = bits [4k+3:4k]; holds the last result
- overflow  output  1  last input exceeded 10^DIGITS-1; holds until the next done

Behaviour:
- Reset (synchronous, active-high) has priority over everything:
  - State goes to IDLE.
  - busy=0, done=0, bcdOut=0, overflow=0.
  - Shift register, scratch BCD register and bit counter are cleared.
  - Reset mid-conversion abandons the conversion; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0.
  - If start=1: latch binaryIn into the shift register, clear the BCD scratch, and load bitCount=BIN_WIDTH.
  - Register ovfPending = (binaryIn > 10^DIGITS-1), using a constant sized to BIN_WIDTH bits, and go to SHIFT.
- SHIFT: busy=1. In one cycle:
  - Every scratch nibble >= 5 gets +3 (4-bit add, no carry between nibbles).
  - Then {scratch, shiftReg} shifts left by 1. The shiftReg MSB enters the scratch LSB.
  - bitCount decrements.
  - When bitCount reaches 1 in this cycle (last shift), go to DONE.
- DONE: busy=1, done=1 for exactly one cycle.
  - bcdOut <= ovfPending ? all nibbles 4'h9 : scratch (saturates to 99999999).
  - overflow <= ovfPending.
  - Return to IDLE.
- Latency:
  - Start accepted at edge N.
  - SHIFT occupies edges N+1 .. N+BIN_WIDTH.
  - done is high and bcdOut is valid after edge N+BIN_WIDTH+1, i.e. 28 clocks for the default.
  - Next start can be accepted on the edge after done (IDLE).
- start while busy=1, including the DONE cycle: ignored, not queued.
- start held high continuously: back-to-back conversions, one every BIN_WIDTH+2 cycles.
- binaryIn changes after acceptance do not affect the conversion in flight.
- bcdOut and overflow change only in the DONE cycle, so the display never shows partial results.
- Scratch width is 4*DIGITS. With DIGITS*log2(10) >= BIN_WIDTH, no bits are lost unless the value overflows. The overflow case is covered by ovfPending saturation.
- Zero input yields all-zero BCD, which the display shows as 00000000; leading-zero blanking is not done here.

Decomposition:
- Shared package holds:
  - The state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - DIGITS and BIN_WIDTH defaults.
  - The BCD_MAX constant (10^DIGITS-1) and BCD_SAT constant (all nibbles 9).
- One natural sub-module, bcd_digit_adjust: purely combinational, 4-bit in/4-bit out, +3 if >=5. Instantiate it DIGITS times via generate.

Test Plan:
- Reset, then start with binaryIn=12345678:
  - busy rises the next cycle.
  - done pulses exactly 28 cycles after start.
  - bcdOut=32'h12345678, overflow=0.
- binaryIn=0 → bcdOut=32'h00000000. binaryIn=99999999 → bcdOut=32'h99999999, overflow=0.
- binaryIn=134217727 (all ones) → overflow=1 and bcdOut=32'h99999999. A following conversion of 42 clears overflow and gives bcdOut=32'h00000042.
- Start pulse with value 5, then start pulses with value 77 on cycles 3, 10 and in the done cycle:
  - Only one done pulse occurs, with bcdOut=32'h00000005.
  - The extra starts are ignored.
- Start 87654321, assert reset at SHIFT cycle 10 for one cycle:
  - busy=0, bcdOut=0, and no done pulse.
  - A new start of 11 then completes in 28 cycles with 32'h00000011.
- start held high with binaryIn ramping:
  - A done pulse occurs every 29 cycles.
  - Each result matches the value present on its accept cycle.
